// File: rtl/layer_vector_packer_pkg.sv
// Shared definitions for the layer vector packer and the layer controller:
// index sizing helper and the packer's FILL/FULL state encoding.
package layer_vector_packer_pkg;

  // Packer state: collecting elements, or holding a complete vector for the consumer.
  typedef enum logic {
    StFill = 1'b0,
    StFull = 1'b1
  } pack_state_e;

  // Bits needed to index 'value' entries (ceil(log2(value)), never less than 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/layer_vector_packer_tc_to_sm.sv
// Two's-complement to sign-magnitude converter. The most negative code has no
// sign-magnitude equivalent and saturates to the largest negative magnitude.
module layer_vector_packer_tc_to_sm #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] tc,
  output logic [DW-1:0] sm
);

  logic [DW-1:0] neg;

  // Magnitude of negative inputs; min code saturates so -0 never appears.
  always_comb begin
    neg = ~tc + DW'(1);
    if (!tc[DW-1]) begin
      sm = tc;
    end else if (tc[DW-2:0] == '0) begin
      sm = '1;
    end else begin
      sm = {1'b1, neg[DW-2:0]};
    end
  end

endmodule

// File: rtl/layer_vector_packer.sv
// Packs N converted activations into one vector for the next layer's datapath.
// Elements arrive one per accept; the full vector is held until the consumer
// takes it, and slots are simply overwritten by the next fill.
module layer_vector_packer
  import layer_vector_packer_pkg::*;
#(
  parameter int unsigned N      = 10,
  parameter int unsigned DW     = 8,
  parameter int unsigned DW_VEC = N * DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic [DW_VEC-1:0]     out_vec,
  output logic [clogb2(N)-1:0]  fill_idx
);

  localparam int unsigned IdxW = clogb2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  pack_state_e   state_q, state_d;
  logic [IdxW-1:0] fill_idx_q, fill_idx_d;
  logic [DW-1:0] slot_q [N];
  logic [DW-1:0] sm_data;
  logic          accept;

  layer_vector_packer_tc_to_sm #(
    .DW (DW)
  ) u_tc_to_sm (
    .tc (in_data),
    .sm (sm_data)
  );

  // State and fill index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFill;
      fill_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
    end
  end

  // Next state: clear overrides both accept and handoff.
  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    if (clear) begin
      state_d    = StFill;
      fill_idx_d = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (fill_idx_q == LastIdx) begin
              state_d    = StFull;
              fill_idx_d = '0;
            end else begin
              fill_idx_d = fill_idx_q + IdxW'(1);
            end
          end
        end
        StFull: begin
          if (vec_ready) begin
            state_d = StFill;
          end
        end
        default: begin
          state_d    = StFill;
          fill_idx_d = '0;
        end
      endcase
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == StFill) && !clear;
    vec_valid = (state_q == StFull);
    fill_idx  = fill_idx_q;
  end

  assign accept = in_valid && in_ready;

  // Slot registers: only the slot at fill_idx is written on an accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(N); k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (accept && (fill_idx_q == IdxW'(k))) begin
          slot_q[k] <= sm_data;
        end
      end
    end
  end

  // Slot k occupies bits [k*DW +: DW] of the packed vector.
  always_comb begin
    out_vec = '0;
    for (int k = 0; k < int'(N); k++) begin
      out_vec[k*DW +: DW] = slot_q[k];
    end
  end

endmodule

// File: tb/tb_layer_vector_packer.sv
// Bench for layer_vector_packer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_layer_vector_packer;

  localparam int N  = 10;
  localparam int DW = 8;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          vec_valid;
  logic          vec_ready;
  logic [VW-1:0] out_vec;
  logic [3:0]    fill_idx;

  always #5 clk = ~clk;

  layer_vector_packer #(
    .N  (N),
    .DW (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .out_vec   (out_vec),
    .fill_idx  (fill_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: slot contents, elements filled, full flag, accepted-element queue.
  logic [DW-1:0] m_slot [N];
  int            m_cnt;
  bit            m_full;
  logic [DW-1:0] m_q [$];
  int            handoffs = 0;

  // Sign-magnitude by integer arithmetic, magnitude capped at 127.
  function automatic logic [DW-1:0] ref_sm(input logic [DW-1:0] x);
    int v;
    int mag;
    v = int'($signed(x));
    if (v >= 0) return x;
    mag = -v;
    if (mag > 127) mag = 127;
    return DW'(128 + mag);
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = m_slot[k];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_slot[k] = '0;
    m_cnt  = 0;
    m_full = 0;
    m_q.delete();
  endtask

  // One clock: drive inputs after a falling edge, check, clock, update model, recheck.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit vr, input bit clr);
    logic [VW-1:0] want;
    in_valid  = v;
    in_data   = d;
    vec_ready = vr;
    clear     = clr;
    #1;
    check_eq("in_ready", VW'(in_ready), VW'(!m_full && !clr));
    if (m_full && vr && !clr) begin
      want = '0;
      for (int k = 0; k < N; k++) begin
        if (m_q.size() > 0) want[k*DW +: DW] = m_q.pop_front();
        else want[k*DW +: DW] = 'x;
      end
      check_eq("handoff_vec", out_vec, want);
      handoffs++;
    end
    @(posedge clk);
    if (clr) begin
      m_cnt  = 0;
      m_full = 0;
      m_q.delete();
    end else if (!m_full && v) begin
      m_slot[m_cnt] = ref_sm(d);
      m_q.push_back(ref_sm(d));
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt  = 0;
        m_full = 1;
      end
    end else if (m_full && vr) begin
      m_full = 0;
    end
    @(negedge clk);
    check_eq("vec_valid", VW'(vec_valid), VW'(m_full));
    check_eq("fill_idx", VW'(fill_idx), VW'(m_cnt));
    check_eq("out_vec", out_vec, model_vec());
  endtask

  logic [VW-1:0] exp_vec;
  logic [DW-1:0] t2_vals [5];
  int            target;
  int            budget;

  initial begin
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    vec_ready = 1'b0;
    model_reset();
    #7;
    check_eq("rst_vec_valid", VW'(vec_valid), '0);
    check_eq("rst_out_vec", out_vec, '0);
    check_eq("rst_fill_idx", VW'(fill_idx), '0);
    check_eq("rst_in_ready", VW'(in_ready), VW'(1));
    @(negedge clk);
    rst = 1'b1;

    // 1: stream 1..10 without consumer
    for (int i = 1; i <= N; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    exp_vec = '0;
    for (int k = 0; k < N; k++) exp_vec[k*DW +: DW] = DW'(k + 1);
    check_eq("t1_slots", out_vec, exp_vec);
    check_eq("t1_vec_valid", VW'(vec_valid), VW'(1));
    in_valid = 1'b1;
    #1;
    check_eq("t1_in_ready", VW'(in_ready), '0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 2: negative, min code, max positive, zero
    t2_vals[0] = 8'hFF;
    t2_vals[1] = 8'hFB;
    t2_vals[2] = 8'h80;
    t2_vals[3] = 8'h7F;
    t2_vals[4] = 8'h00;
    for (int i = 0; i < 5; i++) cycle(1'b1, t2_vals[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    check_eq("t2_slots", VW'(out_vec[39:0]), VW'(40'h00_7F_FF_85_81));

    // 3: hold the full vector 20 cycles, with ignored input traffic
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("t3_in_ready", VW'(in_ready), VW'(1));

    // 4: clear after 4 accepts, then a fresh fill; then clear while full
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, DW'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < N; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 5: asynchronous reset while full
    for (int i = 0; i < N; i++) cycle(1'b1, DW'(i + 100), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("t5_vec_valid", VW'(vec_valid), '0);
    check_eq("t5_out_vec", out_vec, '0);
    check_eq("t5_fill_idx", VW'(fill_idx), '0);
    @(negedge clk);
    rst = 1'b1;

    // 6: random gaps on both sides, 100 vectors
    target = handoffs + 100;
    budget = 20000;
    while (handoffs < target && budget > 0) begin
      cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1, 1'b0);
      budget--;
    end
    check_eq("t6_vectors", VW'(handoffs), VW'(target));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
